axi_lite_slave_bridge: RTL and testbench

Parametrised AXI4-Lite slave that converts bus transactions into simple request/acknowledge accesses to a local memory or register target such as RAM, ROM or peripheral registers. It accepts AW and W independently and in either order, and forwards a write only once both have been received. Read responses are queued in a small response FIFO so the master can apply backpressure on R without stalling the memory side. Error responses from the target are returned as SLVERR.

---
 rtl/axi_lite_pkg.sv | 18 +
 rtl/axil_resp_fifo.sv | 60 ++++++
 rtl/axi_lite_slave_bridge.sv | 171 +++++++++++++++++
 tb/tb_axi_lite_slave_bridge.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - response codes and FSM encodings for the AXI4-Lite slave bridge
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_MEM  = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_MEM  = 1'b1;

  function automatic logic [1:0] resp_of(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axil_resp_fifo.sv
// rtl/axil_resp_fifo.sv - synchronous read-response FIFO, power-of-two depth
module axil_resp_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == DEPTH_C);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/axi_lite_slave_bridge.sv
// rtl/axi_lite_slave_bridge.sv - AXI4-Lite slave to req/ack memory bridge with buffered read responses
module axi_lite_slave_bridge
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int STRB_W   = DATA_W / 8,
  parameter int RD_DEPTH = 2
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [2:0]        AWPROT,
  input  logic              WVALID,
  output logic              WREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [STRB_W-1:0] WSTRB,
  output logic              BVALID,
  input  logic              BREADY,
  output logic [1:0]        BRESP,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [2:0]        ARPROT,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic [STRB_W-1:0] mem_wr_strb,
  input  logic              mem_wr_ack,
  input  logic              mem_wr_err,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_ack,
  input  logic              mem_rd_err,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam int CNT_W = $clog2(RD_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FIFO_DEPTH_C = CNT_W'(RD_DEPTH);

  logic [1:0]          r_wstate;
  logic                r_aw_held;
  logic                r_w_held;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic [STRB_W-1:0]   r_wr_strb;
  logic [1:0]          r_bresp;

  logic [0:0]          r_rstate;
  logic [ADDR_W-1:0]   r_rd_addr;

  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_ar_hs;
  logic                w_push;
  logic                w_pop;
  logic [DATA_W+1:0]   w_fifo_din;
  logic [DATA_W+1:0]   w_fifo_dout;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [CNT_W-1:0]    w_fifo_count;
  logic                w_unused;

  // READYs are masked by reset so they read 0 while ARESETn is held low.
  assign AWREADY = ARESETn && !r_aw_held && (r_wstate == W_IDLE);
  assign WREADY  = ARESETn && !r_w_held && (r_wstate == W_IDLE);
  assign ARREADY = ARESETn && (r_rstate == R_IDLE) && (w_fifo_count < FIFO_DEPTH_C);

  assign w_aw_hs = AWVALID && AWREADY;
  assign w_w_hs  = WVALID && WREADY;
  assign w_ar_hs = ARVALID && ARREADY;

  assign mem_wr_req  = (r_wstate == W_MEM);
  assign mem_wr_addr = r_wr_addr;
  assign mem_wr_data = r_wr_data;
  assign mem_wr_strb = r_wr_strb;
  assign BVALID      = (r_wstate == W_RESP);
  assign BRESP       = r_bresp;

  // A handshake in the current cycle counts as held so mem_wr_req follows the last of AW/W by one cycle.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_wstate  <= W_IDLE;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_strb <= '0;
      r_bresp   <= RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_wr_addr <= AWADDR;
      end
      if (w_w_hs) begin
        r_w_held  <= 1'b1;
        r_wr_data <= WDATA;
        r_wr_strb <= WSTRB;
      end
      case (r_wstate)
        W_IDLE: begin
          if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) begin
            r_wstate <= W_MEM;
          end
        end
        W_MEM: begin
          if (mem_wr_ack) begin
            r_wstate  <= W_RESP;
            r_bresp   <= resp_of(mem_wr_err);
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
          end
        end
        W_RESP: begin
          if (BREADY) begin
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  assign mem_rd_req  = (r_rstate == R_MEM);
  assign mem_rd_addr = r_rd_addr;
  assign w_push      = (r_rstate == R_MEM) && mem_rd_ack;
  assign w_pop       = RVALID && RREADY;
  assign w_fifo_din  = {resp_of(mem_rd_err), mem_rd_data};

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_rstate  <= R_IDLE;
      r_rd_addr <= '0;
    end else if (r_rstate == R_IDLE) begin
      if (w_ar_hs) begin
        r_rd_addr <= ARADDR;
        r_rstate  <= R_MEM;
      end
    end else if (mem_rd_ack) begin
      r_rstate <= R_IDLE;
    end
  end

  axil_resp_fifo #(
    .WIDTH (DATA_W + 2),
    .DEPTH (RD_DEPTH)
  ) u_resp_fifo (
    .i_clk    (ACLK),
    .i_resetn (ARESETn),
    .i_push   (w_push),
    .i_din    (w_fifo_din),
    .i_pop    (w_pop),
    .o_dout   (w_fifo_dout),
    .o_full   (w_fifo_full),
    .o_empty  (w_fifo_empty),
    .o_count  (w_fifo_count)
  );

  assign RVALID = !w_fifo_empty;
  assign RDATA  = w_fifo_dout[DATA_W-1:0];
  assign RRESP  = w_fifo_dout[DATA_W+1:DATA_W];

  assign w_unused = ^{AWPROT, ARPROT, w_fifo_full};

endmodule

// File: tb/tb_axi_lite_slave_bridge.sv
// tb/tb_axi_lite_slave_bridge.sv - self-checking bench for axi_lite_slave_bridge
module tb_axi_lite_slave_bridge;

  localparam int ADDR_W   = 64;
  localparam int DATA_W   = 64;
  localparam int STRB_W   = 8;
  localparam int RD_DEPTH = 2;

  logic              ACLK = 1'b0;
  logic              ARESETn = 1'b0;
  logic              AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic              ARVALID, ARREADY, RVALID, RREADY;
  logic [ADDR_W-1:0] AWADDR, ARADDR, mem_wr_addr, mem_rd_addr;
  logic [2:0]        AWPROT, ARPROT;
  logic [DATA_W-1:0] WDATA, RDATA, mem_wr_data, mem_rd_data;
  logic [STRB_W-1:0] WSTRB, mem_wr_strb;
  logic [1:0]        BRESP, RRESP;
  logic              mem_wr_req, mem_wr_ack, mem_wr_err;
  logic              mem_rd_req, mem_rd_ack, mem_rd_err;

  always #5 ACLK = ~ACLK;

  axi_lite_slave_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W), .RD_DEPTH(RD_DEPTH)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_strb(mem_wr_strb), .mem_wr_ack(mem_wr_ack), .mem_wr_err(mem_wr_err),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_ack(mem_rd_ack),
    .mem_rd_err(mem_rd_err), .mem_rd_data(mem_rd_data)
  );

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } wr_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  wr_t         wr_log[$];
  logic [63:0] rd_log[$];
  int          wr_delay = 0;
  int          rd_delay = 0;
  bit          wr_err = 1'b0;
  bit          rd_err = 1'b0;

  always @(posedge ACLK) cyc <= cyc + 1;

  // Content the target returns for any read address.
  function automatic logic [63:0] rd_value(input logic [63:0] a);
    return {a[31:0] ^ 32'hA5C3_0F1E, ~a[31:0] + 32'h1234_5678};
  endfunction

  // Memory target: acks after the configured number of request cycles.
  initial begin
    int wcnt;
    int rcnt;
    wcnt = 0; rcnt = 0;
    mem_wr_ack = 0; mem_wr_err = 0; mem_rd_ack = 0; mem_rd_err = 0; mem_rd_data = '0;
    forever begin
      @(posedge ACLK); #1;
      mem_rd_data = {$urandom, $urandom};
      if (!ARESETn) begin
        mem_wr_ack = 0; mem_wr_err = 0; mem_rd_ack = 0; mem_rd_err = 0;
        wcnt = 0; rcnt = 0;
      end else begin
        mem_wr_ack = 0; mem_wr_err = 0;
        if (mem_wr_req) begin
          if (wcnt >= wr_delay) begin
            mem_wr_ack = 1; mem_wr_err = wr_err; wcnt = 0;
            wr_log.push_back('{mem_wr_addr, mem_wr_data, mem_wr_strb});
          end else wcnt++;
        end else wcnt = 0;
        mem_rd_ack = 0; mem_rd_err = 0;
        if (mem_rd_req) begin
          if (rcnt >= rd_delay) begin
            mem_rd_ack = 1; mem_rd_err = rd_err; rcnt = 0;
            mem_rd_data = rd_value(mem_rd_addr);
            rd_log.push_back(mem_rd_addr);
          end else rcnt++;
        end else rcnt = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge ACLK); #1;
  endtask

  task automatic send_aw(input logic [63:0] a, input int d, output bit to);
    bit rdy;
    int n = 0;
    repeat (d) tick();
    AWVALID = 1; AWADDR = a; AWPROT = 3'($urandom);
    do begin #1; rdy = AWREADY; tick(); n++; end while (!rdy && n < 100);
    AWVALID = 0; to = !rdy;
  endtask

  task automatic send_w(input logic [63:0] dat, input logic [7:0] s, input int d, output bit to);
    bit rdy;
    int n = 0;
    repeat (d) tick();
    WVALID = 1; WDATA = dat; WSTRB = s;
    do begin #1; rdy = WREADY; tick(); n++; end while (!rdy && n < 100);
    WVALID = 0; to = !rdy;
  endtask

  task automatic send_ar(input logic [63:0] a, output int hs, output bit to);
    bit rdy;
    int n = 0;
    ARVALID = 1; ARADDR = a; ARPROT = 3'($urandom);
    do begin #1; rdy = ARREADY; tick(); hs = cyc; n++; end while (!rdy && n < 100);
    ARVALID = 0; to = !rdy;
  endtask

  task automatic recv_r(output logic [63:0] dat, output logic [1:0] r, output bit to);
    bit v;
    int n = 0;
    RREADY = 1;
    do begin #1; v = RVALID; dat = RDATA; r = RRESP; tick(); n++; end while (!v && n < 100);
    RREADY = 0; to = !v;
  endtask

  task automatic wait_b(output logic [1:0] r, output bit to);
    int n = 0;
    while (!BVALID && n < 100) begin tick(); n++; end
    to = !BVALID; r = BRESP;
    BREADY = 1; tick(); BREADY = 0;
  endtask

  task automatic test_reset();
    ARESETn = 0;
    repeat (3) tick();
    #1;
    checks++; if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b required 000", {AWREADY, WREADY, ARREADY}); end
    checks++; if ({BVALID, RVALID, mem_wr_req, mem_rd_req, BRESP, RRESP} !== 8'h00) begin errors++; $display("FAIL reset_valid_resp: got %h required 00", {BVALID, RVALID, mem_wr_req, mem_rd_req, BRESP, RRESP}); end
    checks++; if ((RDATA | mem_wr_addr | mem_wr_data | mem_rd_addr | 64'(mem_wr_strb)) !== 64'h0) begin errors++; $display("FAIL reset_payload: got nonzero %h required 0", RDATA | mem_wr_addr | mem_wr_data | mem_rd_addr); end
    tick();
    ARESETn = 1; #1;
    checks++; if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin errors++; $display("FAIL release_ready: got %b required 111", {AWREADY, WREADY, ARREADY}); end
    tick();
  endtask

  task automatic test_write_same_cycle();
    wr_delay = 0; wr_err = 0; wr_log.delete();
    AWVALID = 1; AWADDR = 64'h80; WVALID = 1; WDATA = 64'hDEADBEEF; WSTRB = 8'h0F; #1;
    checks++; if ({AWREADY, WREADY} !== 2'b11) begin errors++; $display("FAIL wr1_ready: got %b required 11", {AWREADY, WREADY}); end
    tick(); AWVALID = 0; WVALID = 0; #1;
    checks++; if ({mem_wr_req, BVALID} !== 2'b10) begin errors++; $display("FAIL wr1_req_t1: got req,bvalid=%b required 10", {mem_wr_req, BVALID}); end
    checks++; if ({mem_wr_addr, mem_wr_data, mem_wr_strb} !== {64'h80, 64'hDEADBEEF, 8'h0F}) begin errors++; $display("FAIL wr1_payload: got %h/%h/%h required 80/deadbeef/0f", mem_wr_addr, mem_wr_data, mem_wr_strb); end
    tick(); #1;
    checks++; if ({BVALID, BRESP, mem_wr_req} !== 4'b1000) begin errors++; $display("FAIL wr1_b_t2: got bvalid,bresp,req=%b required 1000", {BVALID, BRESP, mem_wr_req}); end
    BREADY = 1; tick(); BREADY = 0; #1;
    checks++; if ({BVALID, AWREADY, WREADY} !== 3'b011) begin errors++; $display("FAIL wr1_after_b: got bvalid,awready,wready=%b required 011", {BVALID, AWREADY, WREADY}); end
    checks++; if (wr_log.size() != 1) begin errors++; $display("FAIL wr1_count: got %0d writes required 1", wr_log.size()); end
    tick();
  endtask

  task automatic test_w_before_aw();
    logic [63:0] d;
    logic [1:0]  r;
    bit          to;
    wr_t         e;
    d = {$urandom, $urandom};
    wr_delay = 0; wr_err = 0; wr_log.delete();
    WVALID = 1; WDATA = d; WSTRB = 8'hFF; #1;
    checks++; if (WREADY !== 1'b1) begin errors++; $display("FAIL wfirst_wready: got %b required 1", WREADY); end
    tick(); WVALID = 0;
    repeat (3) begin
      #1;
      checks++; if ({mem_wr_req, WREADY, AWREADY} !== 3'b001) begin errors++; $display("FAIL wfirst_wait: got req,wready,awready=%b required 001", {mem_wr_req, WREADY, AWREADY}); end
      tick();
    end
    AWVALID = 1; AWADDR = 64'h40; tick(); AWVALID = 0; #1;
    checks++; if ({mem_wr_req, mem_wr_addr, mem_wr_data} !== {1'b1, 64'h40, d}) begin errors++; $display("FAIL wfirst_req: got %b/%h/%h required 1/40/%h", mem_wr_req, mem_wr_addr, mem_wr_data, d); end
    tick();
    wait_b(r, to);
    checks++; if ({to, r} !== 3'b000) begin errors++; $display("FAIL wfirst_b: got timeout,bresp=%b required 000", {to, r}); end
    checks++;
    if (wr_log.size() != 1) begin errors++; $display("FAIL wfirst_log: got %0d writes required 1", wr_log.size()); end
    else begin
      e = wr_log.pop_front();
      if ({e.addr, e.data, e.strb} !== {64'h40, d, 8'hFF}) begin errors++; $display("FAIL wfirst_log: got %h/%h/%h required 40/%h/ff", e.addr, e.data, e.strb, d); end
    end
  endtask

  task automatic test_write_err_bp();
    bit to1, to2;
    int n = 0;
    wr_delay = 2; wr_err = 1; wr_log.delete();
    fork
      send_aw(64'h1238, 0, to1);
      send_w(64'h0123_4567_89AB_CDEF, 8'h3C, 1, to2);
    join
    while (!BVALID && n < 50) begin tick(); n++; end
    checks++; if ({to1, to2, BVALID} !== 3'b001) begin errors++; $display("FAIL werr_bvalid: got to_aw,to_w,bvalid=%b required 001", {to1, to2, BVALID}); end
    repeat (5) begin
      #1;
      checks++; if ({BVALID, BRESP, AWREADY, WREADY} !== 5'b11000) begin errors++; $display("FAIL werr_hold: got bvalid,bresp,awready,wready=%b required 11000", {BVALID, BRESP, AWREADY, WREADY}); end
      tick();
    end
    BREADY = 1; tick(); BREADY = 0; #1;
    checks++; if ({BVALID, AWREADY} !== 2'b01) begin errors++; $display("FAIL werr_release: got bvalid,awready=%b required 01", {BVALID, AWREADY}); end
    checks++; if (wr_log.size() != 1 || wr_log[0].strb !== 8'h3C) begin errors++; $display("FAIL werr_log: got %0d writes required 1 with strb 3c", wr_log.size()); end
    wr_err = 0; wr_delay = 0;
    tick();
  endtask

  task automatic test_read_backpressure();
    logic [63:0] exp_a [3];
    int hs;
    bit to;
    exp_a[0] = 64'h10; exp_a[1] = 64'h18; exp_a[2] = 64'h20;
    rd_delay = 0; rd_err = 0; RREADY = 0; rd_log.delete();
    send_ar(exp_a[0], hs, to);
    send_ar(exp_a[1], hs, to);
    tick(); tick();
    ARVALID = 1; ARADDR = exp_a[2];
    repeat (3) begin
      #1;
      checks++; if ({ARREADY, RVALID, mem_rd_req} !== 3'b010) begin errors++; $display("FAIL rbp_full: got arready,rvalid,req=%b required 010", {ARREADY, RVALID, mem_rd_req}); end
      tick();
    end
    checks++; if (RDATA !== rd_value(exp_a[0]) || rd_log.size() != 2) begin errors++; $display("FAIL rbp_head: got %h (%0d reads) required %h (2 reads)", RDATA, rd_log.size(), rd_value(exp_a[0])); end
    fork
      send_ar(exp_a[2], hs, to);
      begin
        for (int i = 0; i < 3; i++) begin
          logic [63:0] d;
          logic [1:0]  r;
          bit          rto;
          recv_r(d, r, rto);
          checks++; if ({rto, r, d} !== {1'b0, 2'b00, rd_value(exp_a[i])}) begin errors++; $display("FAIL rbp_drain%0d: got to=%b resp=%b data=%h required 0/00/%h", i, rto, r, d, rd_value(exp_a[i])); end
        end
      end
    join
    checks++; if (rd_log.size() != 3 || rd_log[2] !== exp_a[2]) begin errors++; $display("FAIL rbp_order: got %0d reads required 3 ending at 20", rd_log.size()); end
  endtask

  task automatic test_read_err();
    logic [63:0] a, d;
    logic [1:0]  r;
    int hs;
    bit to, rto;
    a = {$urandom, $urandom} & ~64'h7;
    rd_err = 1; rd_delay = 1;
    send_ar(a, hs, to);
    recv_r(d, r, rto);
    checks++; if ({to, rto, r, d} !== {2'b00, 2'b10, rd_value(a)}) begin errors++; $display("FAIL rerr: got to=%b%b resp=%b data=%h required 00/10/%h", to, rto, r, d, rd_value(a)); end
    rd_err = 0; rd_delay = 0;
  endtask

  task automatic test_back_to_back();
    int hs1, hs2;
    bit to1, to2;
    logic [63:0] a1, a2;
    a1 = 64'h100; a2 = 64'h108;
    rd_delay = 0; rd_err = 0;
    fork
      begin send_ar(a1, hs1, to1); send_ar(a2, hs2, to2); end
      begin
        for (int i = 0; i < 2; i++) begin
          logic [63:0] d;
          logic [1:0]  r;
          bit          rto;
          recv_r(d, r, rto);
          checks++; if ({rto, d} !== {1'b0, rd_value(i == 0 ? a1 : a2)}) begin errors++; $display("FAIL b2b_data%0d: got %h required %h", i, d, rd_value(i == 0 ? a1 : a2)); end
        end
      end
    join
    checks++; if (hs2 - hs1 != 2 || to1 || to2) begin errors++; $display("FAIL b2b_spacing: got %0d cycles required 2", hs2 - hs1); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 16; it++) begin
      logic [63:0] wa, wd, ra;
      logic [7:0]  ws;
      int          gap;
      bit          werr_x, rerr_x;
      wa = {$urandom, $urandom} & ~64'h7;
      wd = {$urandom, $urandom};
      ws = 8'($urandom);
      ra = {$urandom, $urandom} & ~64'h7;
      gap = int'($urandom_range(0, 6)) - 3;
      werr_x = 1'($urandom); rerr_x = 1'($urandom);
      wr_err = werr_x; rd_err = rerr_x;
      wr_delay = $urandom_range(0, 3); rd_delay = $urandom_range(0, 3);
      wr_log.delete();
      fork
        begin
          bit t1, t2, tb;
          logic [1:0] r;
          wr_t e;
          fork
            send_aw(wa, gap > 0 ? gap : 0, t1);
            send_w(wd, ws, gap < 0 ? -gap : 0, t2);
          join
          wait_b(r, tb);
          checks++; if ({t1, t2, tb, r} !== {3'b000, werr_x ? 2'b10 : 2'b00}) begin errors++; $display("FAIL rnd_b%0d: got to=%b%b%b bresp=%b required 000/%b", it, t1, t2, tb, r, werr_x ? 2'b10 : 2'b00); end
          checks++;
          if (wr_log.size() != 1) begin errors++; $display("FAIL rnd_wlog%0d: got %0d writes required 1", it, wr_log.size()); end
          else begin
            e = wr_log.pop_front();
            if ({e.addr, e.data, e.strb} !== {wa, wd, ws}) begin errors++; $display("FAIL rnd_wlog%0d: got %h/%h/%h required %h/%h/%h", it, e.addr, e.data, e.strb, wa, wd, ws); end
          end
        end
        begin
          int hs;
          bit t1, t2;
          logic [63:0] d;
          logic [1:0] r;
          send_ar(ra, hs, t1);
          repeat ($urandom_range(0, 3)) tick();
          recv_r(d, r, t2);
          checks++; if ({t1, t2, r, d} !== {2'b00, rerr_x ? 2'b10 : 2'b00, rd_value(ra)}) begin errors++; $display("FAIL rnd_r%0d: got to=%b%b resp=%b data=%h required 00/%b/%h", it, t1, t2, r, d, rerr_x ? 2'b10 : 2'b00, rd_value(ra)); end
        end
      join
    end
    wr_err = 0; rd_err = 0; wr_delay = 0; rd_delay = 0;
  endtask

  task automatic test_reset_mid_op();
    int hs;
    bit to1, to2, tb;
    logic [1:0]  r;
    logic [63:0] d;
    rd_delay = 0; RREADY = 0;
    send_ar(64'h200, hs, to1);
    tick(); tick();
    rd_delay = 1000; wr_delay = 1000;
    send_ar(64'h208, hs, to1);
    fork
      send_aw(64'h300, 0, to1);
      send_w(64'hCAFE, 8'hFF, 0, to2);
    join
    tick(); #1;
    checks++; if ({mem_wr_req, mem_rd_req, RVALID} !== 3'b111) begin errors++; $display("FAIL rst_mid_pre: got wreq,rreq,rvalid=%b required 111", {mem_wr_req, mem_rd_req, RVALID}); end
    ARESETn = 0; tick(); #1;
    checks++; if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, mem_wr_req, mem_rd_req, BRESP, RRESP} !== 11'h0) begin errors++; $display("FAIL rst_mid_ctrl: got %b required all 0", {AWREADY, WREADY, ARREADY, BVALID, RVALID, mem_wr_req, mem_rd_req, BRESP, RRESP}); end
    checks++; if ((RDATA | mem_wr_addr | mem_wr_data | mem_rd_addr) !== 64'h0) begin errors++; $display("FAIL rst_mid_payload: got %h required 0", RDATA | mem_wr_addr | mem_wr_data | mem_rd_addr); end
    tick(); ARESETn = 1; #1;
    checks++; if ({AWREADY, WREADY, ARREADY, RVALID} !== 4'b1110) begin errors++; $display("FAIL rst_mid_release: got %b required 1110", {AWREADY, WREADY, ARREADY, RVALID}); end
    tick();
    rd_delay = 0; wr_delay = 0; wr_log.delete();
    fork
      send_aw(64'h308, 0, to1);
      send_w(64'hBEEF, 8'h01, 0, to2);
    join
    wait_b(r, tb);
    checks++; if ({to1, to2, tb, r} !== 5'b0 || wr_log.size() != 1 || wr_log[0].addr !== 64'h308) begin errors++; $display("FAIL rst_mid_write: got to=%b%b%b bresp=%b writes=%0d required 000/00/1", to1, to2, tb, r, wr_log.size()); end
    send_ar(64'h210, hs, to1);
    recv_r(d, r, to2);
    checks++; if ({to1, to2, r, d} !== {4'b0000, rd_value(64'h210)}) begin errors++; $display("FAIL rst_mid_read: got resp=%b data=%h required 00/%h", r, d, rd_value(64'h210)); end
  endtask

  initial begin
    AWVALID = 0; AWADDR = '0; AWPROT = '0; WVALID = 0; WDATA = '0; WSTRB = '0; BREADY = 0;
    ARVALID = 0; ARADDR = '0; ARPROT = '0; RREADY = 0;
    test_reset();
    test_write_same_cycle();
    test_w_before_aw();
    test_write_err_bp();
    test_read_backpressure();
    test_read_err();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
